// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes one external hex/BCD segment decoder across eight
// 7-segment digit registers. A load snapshots data/mask/blanking into shadow
// registers, then the scheduler walks digit slots 0..7. Each slot spends one SCAN
// cycle driving the shared decoder and SCAN_DIV-1 WAIT cycles. Loads that arrive
// mid-frame are parked in a pending buffer and start the next frame with no gap.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active low
//   i_load        request to display new data
//   i_data_in     eight nibbles, nibble i drives digit i
//   i_en_mask     per-digit enable, 0 forces the digit blank
//   i_lz_blank    blank leading-zero digits (digit 0 never blanked)
//   o_dec_in      nibble presented to the shared decoder
//   i_dec_out     active-low pattern returned by the decoder (same cycle)
//   o_seg0..7     registered active-low segment patterns, 8'hff = off
//   o_busy        frame in progress
//   o_frame_done  one-cycle pulse after the frame-end edge
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_data_in,
    input  logic [7:0]  i_en_mask,
    input  logic        i_lz_blank,
    output logic [3:0]  o_dec_in,
    input  logic [7:0]  i_dec_out,
    output logic [7:0]  o_seg0,
    output logic [7:0]  o_seg1,
    output logic [7:0]  o_seg2,
    output logic [7:0]  o_seg3,
    output logic [7:0]  o_seg4,
    output logic [7:0]  o_seg5,
    output logic [7:0]  o_seg6,
    output logic [7:0]  o_seg7,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StScan, StWait} state_e;

    state_e          r_state;
    logic [2:0]      r_idx;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_shd_data;
    logic [7:0]      r_shd_mask;
    logic            r_shd_lz;
    logic [31:0]     r_pnd_data;
    logic [7:0]      r_pnd_mask;
    logic            r_pnd_lz;
    logic            r_pnd_vld;
    logic [7:0]      r_seg [8];
    logic            r_frame_done;
    logic [3:0]      r_dec_last;

    state_e          w_state_nxt;
    logic [2:0]      w_idx_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            w_seg_we;
    logic            w_slot_end;
    logic            w_frame_end;
    logic            w_shadow_load;
    logic [3:0]      w_nibble;
    logic            w_upper_zero;
    logic            w_show;
    logic [3:0]      w_dec_in;

    // Digit idx is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        w_nibble     = r_shd_data[{r_idx, 2'b00} +: 4];
        w_upper_zero = ((r_shd_data >> {r_idx, 2'b00}) == 32'd0);
        w_show       = r_shd_mask[r_idx] && !(r_shd_lz && (r_idx != 3'd0) && w_upper_zero);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_seg_we    = 1'b0;
        w_slot_end  = 1'b0;
        w_frame_end = 1'b0;
        w_dec_in    = r_dec_last;

        case (r_state)
            StIdle: begin
                if (i_load) begin
                    w_state_nxt = StScan;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = '0;
                end
            end
            StScan: begin
                w_dec_in = w_nibble;
                w_seg_we = 1'b1;
                if (SCAN_DIV == 1) begin
                    w_slot_end = 1'b1;
                end else begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = CntW'(1);
                end
            end
            StWait: begin
                if (r_cnt == CntLast) begin
                    w_slot_end = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_slot_end) begin
            w_cnt_nxt = '0;
            if (r_idx != 3'd7) begin
                w_state_nxt = StScan;
                w_idx_nxt   = r_idx + 3'd1;
            end else begin
                w_frame_end = 1'b1;
                w_idx_nxt   = 3'd0;
                // A load on the frame-end edge itself restarts just like a pending one.
                w_state_nxt = (i_load || r_pnd_vld) ? StScan : StIdle;
            end
        end

        w_shadow_load = ((r_state == StIdle) && i_load) ||
                        (w_frame_end && (i_load || r_pnd_vld));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_shd_data   <= 32'd0;
            r_shd_mask   <= 8'd0;
            r_shd_lz     <= 1'b0;
            r_pnd_data   <= 32'd0;
            r_pnd_mask   <= 8'd0;
            r_pnd_lz     <= 1'b0;
            r_pnd_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_dec_last   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_seg[i] <= 8'hff;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_done <= w_frame_end;
            r_dec_last   <= w_dec_in;

            if (w_seg_we) begin
                r_seg[r_idx] <= w_show ? i_dec_out : 8'hff;
            end

            // The live inputs win over the pending buffer: they are the newest load.
            if (w_shadow_load) begin
                if (i_load) begin
                    r_shd_data <= i_data_in;
                    r_shd_mask <= i_en_mask;
                    r_shd_lz   <= i_lz_blank;
                end else begin
                    r_shd_data <= r_pnd_data;
                    r_shd_mask <= r_pnd_mask;
                    r_shd_lz   <= r_pnd_lz;
                end
            end

            if (w_frame_end) begin
                r_pnd_vld <= 1'b0;
            end else if (i_load && (r_state != StIdle)) begin
                r_pnd_vld  <= 1'b1;
                r_pnd_data <= i_data_in;
                r_pnd_mask <= i_en_mask;
                r_pnd_lz   <= i_lz_blank;
            end
        end
    end

    always_comb begin
        o_dec_in     = w_dec_in;
        o_busy       = (r_state != StIdle);
        o_frame_done = r_frame_done;
        o_seg0       = r_seg[0];
        o_seg1       = r_seg[1];
        o_seg2       = r_seg[2];
        o_seg3       = r_seg[3];
        o_seg4       = r_seg[4];
        o_seg5       = r_seg[5];
        o_seg6       = r_seg[6];
        o_seg7       = r_seg[7];
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Display scheduler for the eight 7-segment outputs.
- Shares one external combinational hex/BCD decoder across all eight digits: walks digit slots in sequence, drives the shared decoder with each digit's nibble, and registers the returned pattern into that digit's output.
- Provides snapshot loading, per-digit enable, leading-zero blanking, and a busy/frame_done handshake toward the source logic (ALU/encoder/PRBS result paths).

Parameters:
- SCAN_DIV, 4, clock cycles per digit slot (>=1); counter width = clog2(SCAN_DIV) (min 1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- load  input  1  request to display new data; sampled every rising edge.
- data_in  input  32  nibble i = data_in[4i+3:4i] drives digit i.
- en_mask  input  8  bit i=1 enables digit i; 0 forces blank.
- lz_blank  input  1  1 = blank leading zero digits.
- dec_in  output  4  nibble presented to the shared decoder.
- dec_out  input  8  active-low segment pattern from the decoder, valid in the same cycle as dec_in.
- seg0..seg7  output  8 each  registered active-low segment patterns; 8'hff = all off.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, async):
  - seg0..seg7 = 8'hff; busy = 0; frame_done = 0; dec_in = 0.
  - Shadow/pending registers cleared; pending flag cleared; state IDLE; idx = 0; cnt = 0.
  - Reset mid-frame discards the frame and any pending load.
- State machine:
  - IDLE: load=1 captures data_in/en_mask/lz_blank into the shadow registers; go to SCAN, idx = 0.
  - SCAN (1 cycle):
    - dec_in = shadow nibble[idx].
    - At the edge ending the cycle, seg[idx] <= show[idx] ? dec_out : 8'hff.
    - If SCAN_DIV=1: go to the next slot directly. Otherwise go to WAIT with cnt = 1.
  - WAIT: cnt increments. When cnt = SCAN_DIV-1, the slot ends.
  - Slot end:
    - idx < 7: idx++ and go to SCAN.
    - idx = 7: frame end.
- show[idx] rule:
  - show[idx] = en_mask_s[idx] && !lz[idx].
  - lz[i] = lz_blank_s && (i != 0) && (nibbles i..7 of shadow all zero).
  - Digit 0 is never leading-zero blanked.
- Timing: load sampled at edge E0.
  - seg_k updates at edge E0 + 1 + k*SCAN_DIV.
  - Frame end at edge E0 + 8*SCAN_DIV.
  - busy is high from E0 through the frame end. At frame end, busy falls unless a pending load restarts the frame.
  - frame_done is high for exactly the cycle following the frame-end edge.
- dec_in holds the last driven nibble in WAIT/IDLE. Only its value during SCAN cycles is significant.
- Load during a frame (busy=1):
  - Data is captured into the pending buffer and the pending flag is set. Multiple loads: last wins.
  - Segment outputs for the current frame are unaffected.
  - At frame end with pending set: pending is copied to shadow and the flag cleared; state goes to SCAN with idx = 0; busy stays 1; frame_done still pulses.
  - A load on the frame-end edge itself counts as pending and is applied immediately.
- Undriven digits keep their previous pattern until rewritten; no flicker between frames.

Test Plan:
- Reset: hold rst=0 with random inputs → seg0..7 = 8'hff, busy = 0, frame_done = 0. Release; no load → outputs unchanged.
- Basic frame (SCAN_DIV=4, stub decoder = standard hex table):
  - Stimulus: data_in = 32'h76543210, en_mask = 8'hff, lz_blank = 0, load pulse at E0.
  - Required: seg0 = pattern('0') at E0+1, seg7 = pattern('7') at E0+29, frame_done pulse at E0+32, busy high E0..E0+32.
- Mask and leading-zero blanking:
  - Stimulus: data_in = 32'h00000305, en_mask = 8'hfb, lz_blank = 1.
  - Required: seg0 = '5', seg1 = '0', seg2 = 8'hff (masked), seg3..7 = 8'hff (leading zeros).
  - Stimulus: data_in = 0, lz_blank = 1 → seg0 = '0', rest 8'hff.
- Load during frame:
  - Stimulus: load 32'h11111111, then mid-frame load 32'h22222222 followed by 32'h33333333.
  - Required: first frame shows '1' in all digits; second frame starts with no idle gap and shows '3'; two frame_done pulses; busy continuous.
- SCAN_DIV=1: load 32'hfedcba98 → seg_k updated at E0+1+k, frame_done at E0+8; dec_in sequence 8,9,a,b,c,d,e,f.
- Async reset mid-frame: assert rst=0 at E0+10 between edges → outputs return to 8'hff and busy drops to 0 immediately. After release, a fresh load runs a full frame from idx = 0.
